// File: rtl/level_play_sequencer_pkg.sv
// Shared constants for the level/direction sequencer.
// Direction codes match the keypad decoder.
package level_play_sequencer_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_LOAD = 2'd1;
  localparam state_t ST_PLAY = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  localparam logic [7:0] REST_CODE = 8'd0;
  localparam logic [7:0] DIR_UP    = 8'd1;
  localparam logic [7:0] DIR_DOWN  = 8'd2;
  localparam logic [7:0] DIR_LEFT  = 8'd3;
  localparam logic [7:0] DIR_RIGHT = 8'd4;

endpackage

// File: rtl/level_play_sequencer_dir_fifo.sv
// Small synchronous FIFO buffering player directions.
// clr empties it without touching stored data.
module dir_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;

  assign dout  = mem[rd_ptr];
  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;

  // pointer and occupancy tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // data storage, no reset needed
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/level_play_sequencer.sv
// Loads a level chart, then judges buffered directions
// against it on each beat and keeps the score.
module level_play_sequencer
  import level_play_sequencer_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int LVL_DEPTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           lvl_valid,
  input  logic [DATA_W-1:0]              lvl_data,
  input  logic                           lvl_last,
  output logic                           lvl_ready,
  input  logic                           dir_valid,
  input  logic [DATA_W-1:0]              dir_data,
  output logic                           dir_ready,
  input  logic                           step_tick,
  output logic                           out_valid,
  output logic [DATA_W-1:0]              out_expected,
  output logic [DATA_W-1:0]              out_actual,
  output logic                           out_match,
  output logic [$clog2(LVL_DEPTH+1)-1:0] score,
  output logic [$clog2(LVL_DEPTH+1)-1:0] step_idx,
  output logic                           busy,
  output logic                           done
);

  localparam int CW = $clog2(LVL_DEPTH+1);
  localparam int AW = $clog2(LVL_DEPTH);
  localparam int FC = $clog2(FIFO_DEPTH) + 1;

  state_t            state;
  logic [CW-1:0]     lvl_count;
  logic [DATA_W-1:0] mem [LVL_DEPTH];

  logic              f_full;
  logic              f_empty;
  logic [DATA_W-1:0] f_head;
  logic [FC-1:0]     f_count;

  logic              in_play;
  logic              can_start;
  logic              lvl_acc;
  logic              dir_acc;
  logic              tick;
  logic              pop;
  logic              load_end;
  logic              last_step;
  logic [DATA_W-1:0] expect_code;
  logic [DATA_W-1:0] judged;
  logic              hit;

  assign in_play   = (state == ST_PLAY);
  assign can_start = start &
                     ((state == ST_IDLE) |
                      (state == ST_DONE));
  assign lvl_ready = (state == ST_LOAD);
  assign dir_ready = in_play & ~f_full;
  assign busy      = (state == ST_LOAD) | in_play;
  assign done      = (state == ST_DONE);

  assign lvl_acc   = lvl_valid & lvl_ready;
  assign dir_acc   = dir_valid & dir_ready;
  assign tick      = step_tick & in_play;
  assign pop       = tick & ~f_empty;

  assign load_end  = lvl_last |
                     (lvl_count == CW'(LVL_DEPTH-1));
  assign last_step = (step_idx == lvl_count - CW'(1));

  assign expect_code = mem[step_idx[AW-1:0]];
  assign judged      = f_empty ? DATA_W'(REST_CODE)
                               : f_head;
  assign hit         = (expect_code == judged);

  dir_fifo #(
    .W     (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (can_start),
    .push  (dir_acc),
    .pop   (pop),
    .din   (dir_data),
    .dout  (f_head),
    .full  (f_full),
    .empty (f_empty),
    .count (f_count)
  );

  // phase sequencing, judging and scoring
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      lvl_count    <= '0;
      step_idx     <= '0;
      score        <= '0;
      out_valid    <= 1'b0;
      out_expected <= '0;
      out_actual   <= '0;
      out_match    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state     <= ST_LOAD;
            lvl_count <= '0;
            step_idx  <= '0;
            score     <= '0;
          end
        end
        ST_LOAD: begin
          if (lvl_acc) begin
            lvl_count <= lvl_count + CW'(1);
            if (load_end) state <= ST_PLAY;
          end
        end
        ST_PLAY: begin
          if (tick) begin
            out_valid    <= 1'b1;
            out_expected <= expect_code;
            out_actual   <= judged;
            out_match    <= hit;
            score        <= score + CW'(hit);
            step_idx     <= step_idx + CW'(1);
            if (last_step) state <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // level chart storage
  always_ff @(posedge clk) begin
    if (lvl_acc) mem[lvl_count[AW-1:0]] <= lvl_data;
  end

  logic unused_ok;
  assign unused_ok = ^f_count;

endmodule
